// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire layer: one shared datapath walks all neurons per step.
// Optional per-neuron refractory counters are built when LIF_REFRACTORY_EN is defined.
module lif_neuron_array #(
    parameter int N_INPUTS  = 8,
    parameter int N_NEURONS = 4,
    parameter int MEM_W     = $clog2(N_INPUTS) + 2,
    parameter int THR_W     = MEM_W - 1,
    parameter int REFRAC_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
    input  logic [N_INPUTS-1:0]          cfg_weights,
    input  logic                         step_valid,
    output logic                         step_ready,
    input  logic [N_INPUTS-1:0]          inputs,
    input  logic [2:0]                   shift,
    input  logic [THR_W-1:0]             threshold,
    input  logic                         reset_mode,
    input  logic [REFRAC_W-1:0]          refrac_cycles,
    input  logic                         mem_clear,
    output logic [N_NEURONS-1:0]         spikes,
    output logic                         spikes_valid,
    input  logic [$clog2(N_NEURONS)-1:0] mem_sel,
    output logic [MEM_W-1:0]             mem_out
);
    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int ACC_W = MEM_W + 2;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic signed [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] SAT_MAX  = {3'b000, {(MEM_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {3'b111, {(MEM_W-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic signed [MEM_W-1:0] mem     [N_NEURONS];
    logic [N_INPUTS-1:0]     weights [N_NEURONS];
    logic [N_INPUTS-1:0]     inputs_q;
    logic [2:0]              shift_q;
    logic [THR_W-1:0]        thr_q;
    logic                    rmode_q;
    logic [N_NEURONS-1:0]    spike_acc;

`ifdef LIF_REFRACTORY_EN
    logic [REFRAC_W-1:0]     refrac_q;
    logic [REFRAC_W-1:0]     refrac_cnt [N_NEURONS];
`else
    logic                    unused_refrac;
    assign unused_refrac = ^refrac_cycles;
`endif

    logic [N_INPUTS-1:0]     w_cur;
    logic                    in_refrac;
    logic                    fire;
    logic signed [ACC_W-1:0] psp;
    logic signed [ACC_W-1:0] u_ext;
    logic signed [ACC_W-1:0] decayed;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] thr_ext;
    logic signed [MEM_W-1:0] mem_next;
    logic [N_NEURONS-1:0]    spike_vec;

    assign step_ready = (state == IDLE);
    assign mem_out    = mem[mem_sel];

    // Shared datapath for the neuron at slot idx.
    always_comb begin
        w_cur = weights[idx];
`ifdef LIF_REFRACTORY_EN
        in_refrac = (refrac_cnt[idx] != '0);
`else
        in_refrac = 1'b0;
`endif
        psp = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (inputs_q[i]) begin
                psp = w_cur[i] ? psp + ACC_ONE : psp - ACC_ONE;
            end
        end
        if (in_refrac) begin
            psp = '0;
        end

        u_ext = {{2{mem[idx][MEM_W-1]}}, mem[idx]};
        // shift==0 means no leak, not a full leak.
        if (shift_q == 3'd0) begin
            decayed = u_ext;
        end else begin
            decayed = u_ext - (u_ext >>> shift_q);
        end

        sum = decayed + psp;
        if (sum > SAT_MAX) begin
            acc = SAT_MAX;
        end else if (sum < SAT_MIN) begin
            acc = SAT_MIN;
        end else begin
            acc = sum;
        end

        thr_ext = {{(ACC_W-THR_W){1'b0}}, thr_q};
        fire    = !in_refrac && (acc >= thr_ext);

        if (fire && rmode_q) begin
            mem_next = '0;
        end else if (fire) begin
            mem_next = MEM_W'(acc - thr_ext);
        end else begin
            mem_next = acc[MEM_W-1:0];
        end

        spike_vec      = spike_acc;
        spike_vec[idx] = fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            inputs_q     <= '0;
            shift_q      <= '0;
            thr_q        <= '0;
            rmode_q      <= 1'b0;
            spike_acc    <= '0;
            spikes       <= '0;
            spikes_valid <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                mem[n]     <= '0;
                weights[n] <= '0;
`ifdef LIF_REFRACTORY_EN
                refrac_cnt[n] <= '0;
`endif
            end
`ifdef LIF_REFRACTORY_EN
            refrac_q <= '0;
`endif
        end else begin
            spikes_valid <= 1'b0;

            // Weight writes land regardless of state; the slot being processed already read its old row.
            if (cfg_we) begin
                weights[cfg_addr] <= cfg_weights;
            end

            if (mem_clear) begin
                state <= IDLE;
                idx   <= '0;
                for (int n = 0; n < N_NEURONS; n++) begin
                    mem[n] <= '0;
`ifdef LIF_REFRACTORY_EN
                    refrac_cnt[n] <= '0;
`endif
                end
            end else if (state == IDLE) begin
                if (step_valid) begin
                    state     <= RUN;
                    idx       <= '0;
                    inputs_q  <= inputs;
                    shift_q   <= shift;
                    thr_q     <= threshold;
                    rmode_q   <= reset_mode;
                    spike_acc <= '0;
`ifdef LIF_REFRACTORY_EN
                    refrac_q  <= refrac_cycles;
`endif
                end
            end else begin
                mem[idx]  <= mem_next;
                spike_acc <= spike_vec;
`ifdef LIF_REFRACTORY_EN
                if (in_refrac) begin
                    refrac_cnt[idx] <= refrac_cnt[idx] - 1'b1;
                end else if (fire) begin
                    refrac_cnt[idx] <= refrac_q;
                end
`endif
                if (idx == LAST_IDX) begin
                    state        <= IDLE;
                    idx          <= '0;
                    spikes       <= spike_vec;
                    spikes_valid <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule
